uart_tx_fifo: RTL and testbench

- Synchronous first-word-fall-through byte buffer that sits directly upstream of the UART transmitter.
- It accepts bytes from host logic at full clock rate and presents them on the UART's din/din_vld/rfd handshake one byte at a time.
- It decouples bursty producers from the slow serial line.
- It reports fill level, almost-full and a sticky overflow flag.

---
 rtl/uart_pkg.sv | 10 +
 rtl/uart_fifo_ram.sv | 27 ++
 rtl/uart_tx_fifo.sv | 93 +++++++++
 tb/tb_uart_tx_fifo.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared constants and width helpers for the UART datapath.
package uart_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    function automatic int aw_of(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port register array: one write port, one async read port.
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DW = DATA_WIDTH_DEF,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];

    // Contents are intentionally not reset; validity lives in the pointers.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// First-word-fall-through byte buffer feeding the UART transmitter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = 16,
    parameter int AFULL_LVL  = 12,
    localparam int AW        = aw_of(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic [AW:0]           count,
    output logic                  ovf,
    input  logic                  rfd,
    output logic [DATA_WIDTH-1:0] din,
    output logic                  din_vld
);

    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
    localparam logic [AW:0] C_AFULL = (AW+1)'(AFULL_LVL);

    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_ovf;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_we;

    // Flags decode from the registered count, so a full FIFO blocks
    // a push even when a pop frees a slot in the same cycle.
    assign w_full  = (r_count == C_DEPTH);
    assign w_empty = (r_count == '0);
    assign w_push  = wr_en & ~w_full;
    assign w_pop   = ~w_empty & rfd;
    assign w_we    = w_push & rst & ~flush;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (flush) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_push) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_pop) begin
                r_rp <= r_rp + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (wr_en & w_full) begin
                r_ovf <= 1'b1;
            end
        end
    end

    uart_fifo_ram #(
        .DW (DATA_WIDTH),
        .AW (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wp),
        .i_wdata (wr_data),
        .i_raddr (r_rp),
        .o_rdata (din)
    );

    assign full        = w_full;
    assign almost_full = (r_count >= C_AFULL);
    assign count       = r_count;
    assign ovf         = r_ovf;
    assign din_vld     = ~w_empty;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo.
module tb_uart_tx_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AFL   = 12;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          almost_full;
    logic [AW:0]   count;
    logic          ovf;
    logic          rfd;
    logic [DW-1:0] din;
    logic          din_vld;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .AFULL_LVL  (AFL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .ovf         (ovf),
        .rfd         (rfd),
        .din         (din),
        .din_vld     (din_vld)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_state(input string tag);
        check({tag, " din_vld"}, 32'(din_vld), 0);
        check({tag, " count"}, 32'(count), 0);
        check({tag, " full"}, 32'(full), 0);
        check({tag, " ovf"}, 32'(ovf), 0);
    endtask

    initial begin
        rst = 1'b0; flush = 1'b0; wr_en = 1'b0;
        wr_data = '0; rfd = 1'b1;

        // 1: reset then idle
        repeat (3) tick();
        idle_state("rst");
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            idle_state("idle");
        end

        // 2: single word
        rfd = 1'b0; wr_en = 1'b1; wr_data = 8'h64;
        tick();
        wr_en = 1'b0;
        check("sw vld", 32'(din_vld), 1);
        check("sw din", 32'(din), 32'h64);
        check("sw cnt", 32'(count), 1);
        tick();
        check("sw hold din", 32'(din), 32'h64);
        rfd = 1'b1;
        tick();
        rfd = 1'b0;
        check("sw pop cnt", 32'(count), 0);
        check("sw pop vld", 32'(din_vld), 0);

        // 3: fill and overflow
        for (int i = 0; i <= 16; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            tick();
            check("fill cnt", 32'(count), (i < 16) ? i + 1 : 16);
            check("fill afull", 32'(almost_full), (i >= AFL - 1) ? 1 : 0);
            check("fill full", 32'(full), (i >= DEPTH - 1) ? 1 : 0);
            check("fill ovf", 32'(ovf), (i == 16) ? 1 : 0);
        end
        wr_en = 1'b0;
        tick();
        check("ovf sticky", 32'(ovf), 1);
        check("head", 32'(din), 32'h00);

        // 4: full with simultaneous push and pop
        wr_en = 1'b1; wr_data = 8'hAA; rfd = 1'b1;
        tick();
        wr_en = 1'b0;
        check("pp cnt", 32'(count), 15);
        check("pp ovf", 32'(ovf), 1);
        check("pp full", 32'(full), 0);

        for (int k = 1; k < 16; k++) begin
            check("drain vld", 32'(din_vld), 1);
            check("drain din", 32'(din), 32'(k));
            tick();
        end
        check("drain cnt", 32'(count), 0);
        check("drain vld end", 32'(din_vld), 0);
        check("drain ovf", 32'(ovf), 1);

        // 5: flush clears ovf, then streaming across wrap
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush ovf", 32'(ovf), 0);
        rfd = 1'b1;
        for (int j = 0; j <= 40; j++) begin
            wr_en = 1'b1; wr_data = 8'(8'hC8 + j);
            tick();
            check("strm cnt", 32'(count), 1);
            check("strm din", 32'(din), 32'(8'(8'hC8 + j)));
            check("strm ovf", 32'(ovf), 0);
        end
        wr_en = 1'b0;
        tick();
        check("strm end cnt", 32'(count), 0);
        check("strm end vld", 32'(din_vld), 0);

        // 6: flush with concurrent write
        rfd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h30 + i);
            tick();
        end
        check("ld cnt", 32'(count), 5);
        wr_data = 8'h99; flush = 1'b1;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        idle_state("flush");
        tick();
        idle_state("flush2");

        // reset mid-operation with rfd high
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = 8'(8'h40 + i);
            tick();
        end
        check("ld2 cnt", 32'(count), 5);
        wr_data = 8'h77; rfd = 1'b1; rst = 1'b0;
        tick();
        rst = 1'b1; wr_en = 1'b0; rfd = 1'b0;
        idle_state("mrst");
        wr_en = 1'b1; wr_data = 8'h5A;
        tick();
        wr_en = 1'b0;
        check("post din", 32'(din), 32'h5A);
        check("post cnt", 32'(count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
